// File: rtl/decode_stage.sv
// MIPS-I ID stage: decode, branch/jump resolution with delay slot, MEM->ID
// branch forwarding, load-use / branch-operand interlocks and the ID/EX register.
module decode_stage #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter bit          BRANCH_FWD  = 1'b1,
   parameter bit          RESET_PC_WE = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [DATA_WIDTH-1:0] pc,
   input  logic [31:0]           ir,
   input  logic [DATA_WIDTH-1:0] reg_s_data,
   input  logic [DATA_WIDTH-1:0] reg_t_data,
   input  logic                  stall_in,
   input  logic                  flush_in,
   input  logic                  mem_we_fwd,
   input  logic [4:0]            mem_addr_fwd,
   input  logic [DATA_WIDTH-1:0] mem_data_fwd,
   output logic [4:0]            reg_s_addr,
   output logic [4:0]            reg_t_addr,
   output logic                  pc_we,
   output logic [DATA_WIDTH-1:0] pc_data,
   output logic                  stall_out,
   output logic                  valid_ex,
   output logic [3:0]            alu_op_ex,
   output logic                  alu_b_sel_ex,
   output logic                  mem_re_ex,
   output logic                  mem_we_ex,
   output logic                  reg_d_we_ex,
   output logic [4:0]            reg_d_addr_ex,
   output logic [DATA_WIDTH-1:0] imm_ex,
   output logic [DATA_WIDTH-1:0] reg_s_data_ex,
   output logic [DATA_WIDTH-1:0] reg_t_data_ex
);
   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;

   logic [5:0]            w_op, w_funct;
   logic [4:0]            w_rs, w_rt, w_rd;
   logic [3:0]            w_alu_op;
   logic                  w_b_sel, w_mem_re, w_mem_we, w_d_we, w_rd_rt;
   logic [4:0]            w_d_addr;
   logic                  w_d_we_eff, w_rd_rs, w_is_j, w_is_beq, w_is_bne, w_is_br;
   logic [DATA_WIDTH-1:0] w_imm, w_src_s, w_src_t, w_br_tgt, w_j_tgt;
   logic                  w_fwd_s, w_fwd_t, w_load_use, w_ex_src, w_mem_src, w_br_haz;
   logic                  w_hazard, w_taken;

   logic                  r_valid_ex, r_alu_b_sel_ex, r_mem_re_ex, r_mem_we_ex, r_reg_d_we_ex;
   logic [3:0]            r_alu_op_ex;
   logic [4:0]            r_reg_d_addr_ex;
   logic [DATA_WIDTH-1:0] r_imm_ex, r_reg_s_data_ex, r_reg_t_data_ex;

   assign w_op    = ir[31:26];
   assign w_rs    = ir[25:21];
   assign w_rt    = ir[20:16];
   assign w_rd    = ir[15:11];
   assign w_funct = ir[5:0];
   assign w_imm   = {{(DATA_WIDTH-16){ir[15]}}, ir[15:0]};

   always_comb begin
      w_alu_op = '0;
      w_b_sel  = 1'b0;
      w_mem_re = 1'b0;
      w_mem_we = 1'b0;
      w_d_we   = 1'b0;
      w_d_addr = '0;
      w_rd_rt  = 1'b0;
      case (w_op)
         OP_R: begin
            w_rd_rt  = 1'b1;
            w_d_we   = 1'b1;
            w_d_addr = w_rd;
            case (w_funct)
               6'h20:   w_alu_op = 4'd0;
               6'h22:   w_alu_op = 4'd1;
               6'h24:   w_alu_op = 4'd2;
               6'h25:   w_alu_op = 4'd3;
               6'h2A:   w_alu_op = 4'd4;
               default: begin
                  w_d_we   = 1'b0;
                  w_d_addr = '0;
               end
            endcase
         end
         OP_ADDI: begin
            w_b_sel  = 1'b1;
            w_d_we   = 1'b1;
            w_d_addr = w_rt;
         end
         OP_LW: begin
            w_b_sel  = 1'b1;
            w_mem_re = 1'b1;
            w_d_we   = 1'b1;
            w_d_addr = w_rt;
         end
         OP_SW: begin
            w_b_sel  = 1'b1;
            w_mem_we = 1'b1;
            w_rd_rt  = 1'b1;
         end
         OP_BEQ, OP_BNE: w_rd_rt = 1'b1;
         default: ;
      endcase
   end

   assign w_d_we_eff = w_d_we & (w_d_addr != '0);
   assign w_rd_rs    = (w_op != OP_J);
   assign w_is_j     = (w_op == OP_J);
   assign w_is_beq   = (w_op == OP_BEQ);
   assign w_is_bne   = (w_op == OP_BNE);
   assign w_is_br    = w_is_beq | w_is_bne;

   // MEM result bypasses the regfile for both the comparator and EX operands
   assign w_fwd_s = BRANCH_FWD & mem_we_fwd & (mem_addr_fwd == w_rs) & (w_rs != '0);
   assign w_fwd_t = BRANCH_FWD & mem_we_fwd & (mem_addr_fwd == w_rt) & (w_rt != '0);
   assign w_src_s = w_fwd_s ? mem_data_fwd : reg_s_data;
   assign w_src_t = w_fwd_t ? mem_data_fwd : reg_t_data;

   assign w_load_use = r_valid_ex & r_mem_re_ex & (r_reg_d_addr_ex != '0) &
                       ((w_rd_rs & (r_reg_d_addr_ex == w_rs)) |
                        (w_rd_rt & (r_reg_d_addr_ex == w_rt)));
   assign w_ex_src   = (r_reg_d_addr_ex == w_rs) | (r_reg_d_addr_ex == w_rt);
   assign w_mem_src  = mem_we_fwd & (mem_addr_fwd != '0) &
                       ((mem_addr_fwd == w_rs) | (mem_addr_fwd == w_rt));
   // without forwarding, an in-flight MEM write must reach the regfile first
   assign w_br_haz   = w_is_br & ((r_valid_ex & r_reg_d_we_ex & (r_reg_d_addr_ex != '0) & w_ex_src) |
                                  (!BRANCH_FWD & w_mem_src));
   assign w_hazard   = id_valid & (w_load_use | w_br_haz);

   assign w_taken  = (w_is_beq & (w_src_s == w_src_t)) | (w_is_bne & (w_src_s != w_src_t));
   assign w_br_tgt = pc + {w_imm[DATA_WIDTH-3:0], 2'b00};
   assign w_j_tgt  = {pc[DATA_WIDTH-1:28], ir[25:0], 2'b00};

   assign reg_s_addr = w_rs;
   assign reg_t_addr = w_rt;
   assign pc_data    = w_is_j ? w_j_tgt : w_br_tgt;
   assign pc_we      = rst ? RESET_PC_WE :
                       (id_valid & (w_is_j | w_taken) & !w_hazard & !stall_in & !flush_in);
   assign stall_out  = id_valid & (w_hazard | stall_in) & !flush_in & !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid_ex      <= 1'b0;
         r_alu_op_ex     <= '0;
         r_alu_b_sel_ex  <= 1'b0;
         r_mem_re_ex     <= 1'b0;
         r_mem_we_ex     <= 1'b0;
         r_reg_d_we_ex   <= 1'b0;
         r_reg_d_addr_ex <= '0;
         r_imm_ex        <= '0;
         r_reg_s_data_ex <= '0;
         r_reg_t_data_ex <= '0;
      end else if (flush_in || (!stall_in && (w_hazard || !id_valid))) begin
         // kill or bubble: data fields hold, only valid and enables drop
         r_valid_ex    <= 1'b0;
         r_mem_re_ex   <= 1'b0;
         r_mem_we_ex   <= 1'b0;
         r_reg_d_we_ex <= 1'b0;
      end else if (!stall_in) begin
         r_valid_ex      <= 1'b1;
         r_alu_op_ex     <= w_alu_op;
         r_alu_b_sel_ex  <= w_b_sel;
         r_mem_re_ex     <= w_mem_re;
         r_mem_we_ex     <= w_mem_we;
         r_reg_d_we_ex   <= w_d_we_eff;
         r_reg_d_addr_ex <= w_d_addr;
         r_imm_ex        <= w_imm;
         r_reg_s_data_ex <= w_src_s;
         r_reg_t_data_ex <= w_src_t;
      end
   end

   assign valid_ex      = r_valid_ex;
   assign alu_op_ex     = r_alu_op_ex;
   assign alu_b_sel_ex  = r_alu_b_sel_ex;
   assign mem_re_ex     = r_mem_re_ex;
   assign mem_we_ex     = r_mem_we_ex;
   assign reg_d_we_ex   = r_reg_d_we_ex;
   assign reg_d_addr_ex = r_reg_d_addr_ex;
   assign imm_ex        = r_imm_ex;
   assign reg_s_data_ex = r_reg_s_data_ex;
   assign reg_t_data_ex = r_reg_t_data_ex;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an instruction-level model checks every cycle,
// and hand-computed expectations pin the main scenarios (forwarding and no-forwarding).
module tb_decode_stage;
   logic        clk = 1'b0;
   logic        rst, id_valid, stall_in, flush_in, mem_we_fwd;
   logic [31:0] pc, ir, reg_s_data, reg_t_data, mem_data_fwd;
   logic [4:0]  mem_addr_fwd;

   logic [4:0]  reg_s_addr, reg_t_addr, reg_d_addr_ex;
   logic        pc_we, stall_out, valid_ex, alu_b_sel_ex, mem_re_ex, mem_we_ex, reg_d_we_ex;
   logic [31:0] pc_data, imm_ex, reg_s_data_ex, reg_t_data_ex;
   logic [3:0]  alu_op_ex;

   logic [4:0]  nf_s_addr, nf_t_addr, nf_d_addr_ex;
   logic        nf_pc_we, nf_stall_out, nf_valid_ex, nf_b_sel_ex, nf_re_ex, nf_we_ex, nf_d_we_ex;
   logic [31:0] nf_pc_data, nf_imm_ex, nf_s_data_ex, nf_t_data_ex;
   logic [3:0]  nf_alu_op_ex;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   decode_stage #(.DATA_WIDTH(32), .BRANCH_FWD(1'b1), .RESET_PC_WE(1'b0)) u_dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .pc(pc), .ir(ir),
      .reg_s_data(reg_s_data), .reg_t_data(reg_t_data), .stall_in(stall_in), .flush_in(flush_in),
      .mem_we_fwd(mem_we_fwd), .mem_addr_fwd(mem_addr_fwd), .mem_data_fwd(mem_data_fwd),
      .reg_s_addr(reg_s_addr), .reg_t_addr(reg_t_addr), .pc_we(pc_we), .pc_data(pc_data),
      .stall_out(stall_out), .valid_ex(valid_ex), .alu_op_ex(alu_op_ex), .alu_b_sel_ex(alu_b_sel_ex),
      .mem_re_ex(mem_re_ex), .mem_we_ex(mem_we_ex), .reg_d_we_ex(reg_d_we_ex),
      .reg_d_addr_ex(reg_d_addr_ex), .imm_ex(imm_ex), .reg_s_data_ex(reg_s_data_ex),
      .reg_t_data_ex(reg_t_data_ex));

   decode_stage #(.DATA_WIDTH(32), .BRANCH_FWD(1'b0), .RESET_PC_WE(1'b0)) u_dut_nf (
      .clk(clk), .rst(rst), .id_valid(id_valid), .pc(pc), .ir(ir),
      .reg_s_data(reg_s_data), .reg_t_data(reg_t_data), .stall_in(stall_in), .flush_in(flush_in),
      .mem_we_fwd(mem_we_fwd), .mem_addr_fwd(mem_addr_fwd), .mem_data_fwd(mem_data_fwd),
      .reg_s_addr(nf_s_addr), .reg_t_addr(nf_t_addr), .pc_we(nf_pc_we), .pc_data(nf_pc_data),
      .stall_out(nf_stall_out), .valid_ex(nf_valid_ex), .alu_op_ex(nf_alu_op_ex), .alu_b_sel_ex(nf_b_sel_ex),
      .mem_re_ex(nf_re_ex), .mem_we_ex(nf_we_ex), .reg_d_we_ex(nf_d_we_ex),
      .reg_d_addr_ex(nf_d_addr_ex), .imm_ex(nf_imm_ex), .reg_s_data_ex(nf_s_data_ex),
      .reg_t_data_ex(nf_t_data_ex));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
      rtype = {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
   endfunction
   function automatic logic [31:0] itype(input int op, input int rs, input int rt, input logic [15:0] im);
      itype = {op[5:0], rs[4:0], rt[4:0], im};
   endfunction
   function automatic logic [31:0] jtype(input logic [25:0] tg);
      jtype = {6'h02, tg};
   endfunction

   // ---------------- instruction-level model (forwarding variant) ----------------
   typedef struct {
      bit vld, re, we, dwe, bsel;
      logic [3:0] alu;
      logic [4:0] dad;
      logic [31:0] imm, sd, td;
   } ex_t;

   ex_t m = '{default: 0};

   task automatic eval(output bit pcwe, output logic [31:0] pcd, output bit stl, output ex_t nx);
      int op, fn, rs, rt, rd;
      bit known, rd_rs, rd_rt, lu, bh, haz, taken;
      logic [31:0] sv, tv, im;
      ex_t d;
      op = int'(ir[31:26]); fn = int'(ir[5:0]);
      rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
      im = {{16{ir[15]}}, ir[15:0]};
      sv = (mem_we_fwd && int'(mem_addr_fwd) == rs && rs != 0) ? mem_data_fwd : reg_s_data;
      tv = (mem_we_fwd && int'(mem_addr_fwd) == rt && rt != 0) ? mem_data_fwd : reg_t_data;
      d = '{default: 0};
      d.vld = 1; d.imm = im; d.sd = sv; d.td = tv;
      known = (fn == 'h20 || fn == 'h22 || fn == 'h24 || fn == 'h25 || fn == 'h2A);
      if (op == 0 && known) begin
         d.alu = (fn == 'h20) ? 4'd0 : (fn == 'h22) ? 4'd1 : (fn == 'h24) ? 4'd2 : (fn == 'h25) ? 4'd3 : 4'd4;
         d.dad = rd[4:0]; d.dwe = (rd != 0);
      end else if (op == 'h08 || op == 'h23) begin
         d.bsel = 1; d.dad = rt[4:0]; d.dwe = (rt != 0); d.re = (op == 'h23);
      end else if (op == 'h2B) begin
         d.bsel = 1; d.we = 1;
      end
      rd_rs = (op != 2);
      rd_rt = (op == 0 || op == 'h2B || op == 4 || op == 5);
      lu = m.vld && m.re && m.dad != 0 &&
           ((rd_rs && int'(m.dad) == rs) || (rd_rt && int'(m.dad) == rt));
      bh = (op == 4 || op == 5) && m.vld && m.dwe && m.dad != 0 &&
           (int'(m.dad) == rs || int'(m.dad) == rt);
      haz   = id_valid && (lu || bh);
      taken = (op == 4 && sv == tv) || (op == 5 && sv != tv);
      pcwe  = !rst && id_valid && (op == 2 || taken) && !haz && !stall_in && !flush_in;
      pcd   = (op == 2) ? {pc[31:28], ir[25:0], 2'b00} : pc + (im * 4);
      stl   = !rst && id_valid && (haz || stall_in) && !flush_in;
      nx = m;
      if (rst) nx = '{default: 0};
      else if (flush_in || (!stall_in && (haz || !id_valid))) begin
         nx.vld = 0; nx.re = 0; nx.we = 0; nx.dwe = 0;
      end else if (!stall_in) nx = d;
   endtask

   bit c_pcwe, c_stl;
   logic [31:0] c_pcd;
   ex_t c_nx;
   always @(negedge clk) begin
      if (chk_en) begin
         eval(c_pcwe, c_pcd, c_stl, c_nx);
         chk("m_pc_we", pc_we, c_pcwe);
         if (c_pcwe) chk("m_pc_data", pc_data, c_pcd);
         chk("m_stall_out", stall_out, c_stl);
         chk("m_rs_addr", reg_s_addr, ir[25:21]);
         chk("m_rt_addr", reg_t_addr, ir[20:16]);
         chk("m_valid_ex", valid_ex, m.vld);
         chk("m_mem_re_ex", mem_re_ex, m.re);
         chk("m_mem_we_ex", mem_we_ex, m.we);
         chk("m_d_we_ex", reg_d_we_ex, m.dwe);
         if (m.vld) begin
            chk("m_alu_op_ex", alu_op_ex, m.alu);
            chk("m_b_sel_ex", alu_b_sel_ex, m.bsel);
            chk("m_d_addr_ex", reg_d_addr_ex, m.dad);
            chk("m_imm_ex", imm_ex, m.imm);
            chk("m_s_data_ex", reg_s_data_ex, m.sd);
            chk("m_t_data_ex", reg_t_data_ex, m.td);
         end
      end
   end

   bit u_pcwe, u_stl;
   logic [31:0] u_pcd;
   ex_t u_nx;
   always @(posedge clk) begin
      eval(u_pcwe, u_pcd, u_stl, u_nx);
      m <= u_nx;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // ---------------- directed table ----------------
   logic [31:0] t_ir [12];
   bit          t_stl[12], t_vn[12], t_dwe[12];
   logic [3:0]  t_alu[12];

   initial begin
      t_ir[0]  = itype('h08, 1, 8, 16'hFFFB); t_stl[0]  = 0; t_vn[0]  = 1; t_dwe[0]  = 1; t_alu[0]  = 0;
      t_ir[1]  = rtype(1, 2, 9, 'h24);        t_stl[1]  = 0; t_vn[1]  = 1; t_dwe[1]  = 1; t_alu[1]  = 2;
      t_ir[2]  = rtype(1, 2, 10, 'h25);       t_stl[2]  = 0; t_vn[2]  = 1; t_dwe[2]  = 1; t_alu[2]  = 3;
      t_ir[3]  = rtype(1, 2, 11, 'h2A);       t_stl[3]  = 0; t_vn[3]  = 1; t_dwe[3]  = 1; t_alu[3]  = 4;
      t_ir[4]  = itype('h2B, 1, 2, 16'h0004); t_stl[4]  = 0; t_vn[4]  = 1; t_dwe[4]  = 0; t_alu[4]  = 0;
      t_ir[5]  = rtype(1, 2, 0, 'h20);        t_stl[5]  = 0; t_vn[5]  = 1; t_dwe[5]  = 0; t_alu[5]  = 0;
      t_ir[6]  = itype('h3F, 1, 2, 16'h0007); t_stl[6]  = 0; t_vn[6]  = 1; t_dwe[6]  = 0; t_alu[6]  = 0;
      t_ir[7]  = rtype(1, 2, 12, 'h00);       t_stl[7]  = 0; t_vn[7]  = 1; t_dwe[7]  = 0; t_alu[7]  = 0;
      t_ir[8]  = itype('h23, 1, 13, 16'h0008);t_stl[8]  = 0; t_vn[8]  = 1; t_dwe[8]  = 1; t_alu[8]  = 0;
      t_ir[9]  = itype('h04, 13, 2, 16'h0002);t_stl[9]  = 1; t_vn[9]  = 0; t_dwe[9]  = 0; t_alu[9]  = 0;
      t_ir[10] = itype('h08, 1, 14, 16'h0001);t_stl[10] = 0; t_vn[10] = 1; t_dwe[10] = 1; t_alu[10] = 0;
      t_ir[11] = itype('h05, 14, 0, 16'h0003);t_stl[11] = 1; t_vn[11] = 0; t_dwe[11] = 0; t_alu[11] = 0;
   end

   initial begin
      rst = 1; id_valid = 1; ir = jtype(26'h40); pc = 32'h8000_0004;
      reg_s_data = 0; reg_t_data = 0; stall_in = 0; flush_in = 0;
      mem_we_fwd = 0; mem_addr_fwd = 0; mem_data_fwd = 0;
      tick(); tick();
      chk_en = 1;
      @(negedge clk);
      chk("rst_valid_ex", valid_ex, 0);
      chk("rst_d_we_ex", reg_d_we_ex, 0);
      chk("rst_imm_ex", imm_ex, 0);
      chk("rst_s_data_ex", reg_s_data_ex, 0);
      chk("rst_pc_we", pc_we, 0);
      chk("rst_stall_out", stall_out, 0);
      tick();

      // ADD r3,r1,r2
      rst = 0; ir = rtype(1, 2, 3, 'h20); pc = 32'h100; reg_s_data = 5; reg_t_data = 7;
      @(negedge clk);
      chk("add_pc_we", pc_we, 0);
      chk("add_rs_addr", reg_s_addr, 1);
      tick();
      id_valid = 0;
      @(negedge clk);
      chk("add_valid_ex", valid_ex, 1);
      chk("add_alu_op", alu_op_ex, 0);
      chk("add_d_addr", reg_d_addr_ex, 3);
      chk("add_s_data", reg_s_data_ex, 5);
      chk("add_t_data", reg_t_data_ex, 7);
      tick();

      // LW r4,0(r1) ; ADD r5,r4,r4
      id_valid = 1; ir = itype('h23, 1, 4, 16'h0000); reg_s_data = 32'h40;
      tick();
      ir = rtype(4, 4, 5, 'h20); reg_s_data = 0; reg_t_data = 0;
      @(negedge clk);
      chk("lu_stall_out", stall_out, 1);
      tick();
      @(negedge clk);
      chk("lu_bubble_valid", valid_ex, 0);
      chk("lu_reissue_stall", stall_out, 0);
      tick();
      id_valid = 0;
      @(negedge clk);
      chk("lu_add_valid", valid_ex, 1);
      chk("lu_add_d_addr", reg_d_addr_ex, 5);
      tick();

      // BEQ / BNE at pc 0x104
      id_valid = 1; pc = 32'h104; ir = itype('h04, 1, 2, 16'h0003); reg_s_data = 9; reg_t_data = 9;
      @(negedge clk);
      chk("beq_eq_pc_we", pc_we, 1);
      chk("beq_eq_target", pc_data, 32'h110);
      tick();
      reg_t_data = 8;
      @(negedge clk);
      chk("beq_ne_pc_we", pc_we, 0);
      tick();
      ir = itype('h05, 1, 2, 16'h0003);
      @(negedge clk);
      chk("bne_ne_pc_we", pc_we, 1);
      chk("bne_target", pc_data, 32'h110);
      tick();
      ir = itype('h04, 1, 2, 16'hFFFE); reg_t_data = 9;
      @(negedge clk);
      chk("beq_back_target", pc_data, 32'h0FC);
      tick();

      // BEQ r6,r0 with r6 in MEM
      pc = 32'h200; ir = itype('h04, 6, 0, 16'h0001); reg_s_data = 1; reg_t_data = 0;
      mem_we_fwd = 1; mem_addr_fwd = 6; mem_data_fwd = 0;
      @(negedge clk);
      chk("fwd_pc_we", pc_we, 1);
      chk("fwd_target", pc_data, 32'h204);
      chk("fwd_stall_out", stall_out, 0);
      chk("nf_stall_out", nf_stall_out, 1);
      chk("nf_pc_we_held", nf_pc_we, 0);
      tick();
      mem_we_fwd = 0; mem_addr_fwd = 0; reg_s_data = 0;
      @(negedge clk);
      chk("nf_bubble_valid", nf_valid_ex, 0);
      chk("nf_stall_clear", nf_stall_out, 0);
      chk("nf_pc_we_taken", nf_pc_we, 1);
      chk("nf_target", nf_pc_data, 32'h204);
      tick();

      // J with and without flush
      pc = 32'h8000_0004; ir = jtype(26'h40);
      @(negedge clk);
      chk("j_pc_we", pc_we, 1);
      chk("j_target", pc_data, 32'h8000_0100);
      tick();
      flush_in = 1;
      @(negedge clk);
      chk("j_flush_pc_we", pc_we, 0);
      chk("j_flush_stall", stall_out, 0);
      tick();
      flush_in = 0; id_valid = 0;
      @(negedge clk);
      chk("j_flush_valid_ex", valid_ex, 0);
      tick();

      // stall_in held 3 cycles, then rst mid-stall
      id_valid = 1; pc = 32'h300; ir = rtype(1, 2, 3, 'h20); reg_s_data = 11; reg_t_data = 22;
      tick();
      stall_in = 1; ir = rtype(7, 8, 9, 'h22); reg_s_data = 99; reg_t_data = 98;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid_ex", valid_ex, 1);
         chk("stall_d_addr", reg_d_addr_ex, 3);
         chk("stall_s_data", reg_s_data_ex, 11);
         chk("stall_t_data", reg_t_data_ex, 22);
         chk("stall_out_fwd", stall_out, 1);
         tick();
      end
      rst = 1;
      tick();
      @(negedge clk);
      chk("rst_stall_valid", valid_ex, 0);
      chk("rst_stall_d_addr", reg_d_addr_ex, 0);
      chk("rst_stall_s_data", reg_s_data_ex, 0);
      chk("rst_stall_out", stall_out, 0);
      tick();
      rst = 0; stall_in = 0;

      // back-to-back table
      for (int i = 0; i < 12; i++) begin
         ir = t_ir[i]; pc = 32'h400 + 32'(i * 4);
         reg_s_data = 32'(i * 3 + 1); reg_t_data = 32'(i * 5 + 2);
         @(negedge clk);
         chk("tbl_stall", stall_out, t_stl[i]);
         if (i > 0) begin
            chk("tbl_valid", valid_ex, t_vn[i-1]);
            chk("tbl_d_we", reg_d_we_ex, t_dwe[i-1]);
            if (t_vn[i-1]) chk("tbl_alu", alu_op_ex, t_alu[i-1]);
         end
         tick();
      end
      id_valid = 0;
      @(negedge clk);
      chk("tbl_last_valid", valid_ex, t_vn[11]);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
